// File: rtl/instr_register_exec.sv
// Instruction register with an execute unit: single-cycle ALU ops plus an
// iterative restoring divider for DIV/MOD, committed into a DEPTH-entry array.
module instr_register_exec #(
  parameter int unsigned OP_WIDTH = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_en,
  output logic                load_ready,
  input  logic [3:0]          opcode,
  input  logic [OP_WIDTH-1:0] operand_a,
  input  logic [OP_WIDTH-1:0] operand_b,
  input  logic [AW-1:0]       write_pointer,
  input  logic [AW-1:0]       read_pointer,
  output logic [3:0]          rd_opc,
  output logic [OP_WIDTH-1:0] rd_op_a,
  output logic [OP_WIDTH-1:0] rd_op_b,
  output logic [OP_WIDTH-1:0] rd_rezultat,
  output logic                rd_valid,
  output logic                rd_err,
  output logic                done
);
  localparam int unsigned W    = OP_WIDTH;
  localparam logic [6:0]  LAST = 7'(OP_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DIV} state_t;

  state_t          state_q, state_d;
  logic [3:0]      opc_q, opc_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [W-1:0]    quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [3:0]      mem_opc_q [DEPTH];
  logic [W-1:0]    mem_a_q   [DEPTH];
  logic [W-1:0]    mem_b_q   [DEPTH];
  logic [W-1:0]    mem_res_q [DEPTH];
  logic [DEPTH-1:0] mem_valid_q, mem_err_q;

  logic [W:0]      rem_shift;
  logic [W-1:0]    rem_sub, rem_next, quo_next, div_res, calc_res, commit_res;
  logic            bit_one, calc_err, commit_en, commit_err;

  // One restoring step; on the final DIV cycle its output feeds the sign fix directly.
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    bit_one   = rem_shift >= {1'b0, dvs_q};
    rem_sub   = rem_shift[W-1:0] - dvs_q;
    rem_next  = bit_one ? rem_sub : rem_shift[W-1:0];
    quo_next  = {quo_q[W-2:0], bit_one};
    if (opc_q == 4'd6) div_res = (a_q[W-1] ^ b_q[W-1]) ? -quo_next : quo_next;
    else               div_res = a_q[W-1] ? -rem_next : rem_next;
  end

  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    case (opc_q)
      4'd0:    calc_res = '0;
      4'd1:    calc_res = a_q;
      4'd2:    calc_res = b_q;
      4'd3:    calc_res = a_q + b_q;
      4'd4:    calc_res = a_q - b_q;
      4'd5:    calc_res = a_q * b_q;
      default: calc_err = 1'b1;  // divide-by-zero reaches CALC as DIV/MOD
    endcase
  end

  always_comb begin
    commit_en  = (state_q == CALC) || (state_q == DIV && cnt_q == LAST);
    commit_res = (state_q == DIV) ? div_res : calc_res;
    commit_err = (state_q == DIV) ? 1'b0 : calc_err;
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    wp_d    = wp_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = commit_en;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          opc_d = opcode;
          a_d   = operand_a;
          b_d   = operand_b;
          wp_d  = write_pointer;
          if ((opcode == 4'd6 || opcode == 4'd7) && operand_b != '0) begin
            state_d = DIV;
            cnt_d   = '0;
            quo_d   = operand_a[W-1] ? -operand_a : operand_a;
            rem_d   = '0;
            dvs_d   = operand_b[W-1] ? -operand_b : operand_b;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: state_d = IDLE;
      DIV: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wp_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_opc_q[i] <= '0;
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_res_q[i] <= '0;
      end
      mem_valid_q <= '0;
      mem_err_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wp_q    <= wp_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (commit_en) begin
        mem_opc_q[wp_q]   <= opc_q;
        mem_a_q[wp_q]     <= a_q;
        mem_b_q[wp_q]     <= b_q;
        mem_res_q[wp_q]   <= commit_res;
        mem_valid_q[wp_q] <= 1'b1;
        mem_err_q[wp_q]   <= commit_err;
      end
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign done        = done_q;
  assign rd_opc      = mem_opc_q[read_pointer];
  assign rd_op_a     = mem_a_q[read_pointer];
  assign rd_op_b     = mem_b_q[read_pointer];
  assign rd_rezultat = mem_res_q[read_pointer];
  assign rd_valid    = mem_valid_q[read_pointer];
  assign rd_err      = mem_err_q[read_pointer];

endmodule

// File: tb/tb_instr_register_exec.sv
// Scoreboard bench for instr_register_exec: 32-bit/32-entry and 8-bit/4-entry
// instances, expected entries queued at accept and checked on each done pulse.
module tb_instr_register_exec;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int unsigned ptr;
    logic [3:0]  opc;
    logic [63:0] a, b, res;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq8[$];

  // 32-bit instance
  logic        reset_n, load_en, load_ready, rd_valid, rd_err, done;
  logic [3:0]  opcode, rd_opc;
  logic [31:0] operand_a, operand_b, rd_op_a, rd_op_b, rd_rezultat;
  logic [4:0]  write_pointer, read_pointer;

  instr_register_exec #(.OP_WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_ready(load_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .rd_opc(rd_opc), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
    .rd_rezultat(rd_rezultat), .rd_valid(rd_valid), .rd_err(rd_err), .done(done)
  );

  // 8-bit instance
  logic       r8_reset_n, r8_load_en, r8_load_ready, r8_rd_valid, r8_rd_err, r8_done;
  logic [3:0] r8_opcode, r8_rd_opc;
  logic [7:0] r8_a, r8_b, r8_rd_a, r8_rd_b, r8_rd_res;
  logic [1:0] r8_wp, r8_rp;

  instr_register_exec #(.OP_WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .reset_n(r8_reset_n), .load_en(r8_load_en), .load_ready(r8_load_ready),
    .opcode(r8_opcode), .operand_a(r8_a), .operand_b(r8_b),
    .write_pointer(r8_wp), .read_pointer(r8_rp),
    .rd_opc(r8_rd_opc), .rd_op_a(r8_rd_a), .rd_op_b(r8_rd_b),
    .rd_rezultat(r8_rd_res), .rd_valid(r8_rd_valid), .rd_err(r8_rd_err), .done(r8_done)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_done32", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        read_pointer = e.ptr[4:0];
        #1;
        check("latency32", 64'(cyc), 64'(e.due));
        check("opc32", 64'(rd_opc), 64'(e.opc));
        check("op_a32", 64'(rd_op_a), e.a);
        check("op_b32", 64'(rd_op_b), e.b);
        check("res32", 64'(rd_rezultat), e.res);
        check("valid32", 64'(rd_valid), 64'd1);
        check("err32", 64'(rd_err), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (r8_done === 1'b1) begin
      if (sbq8.size() == 0) begin
        check("spurious_done8", 64'd1, 64'd0);
      end else begin
        e = sbq8.pop_front();
        r8_rp = e.ptr[1:0];
        #1;
        check("latency8", 64'(cyc), 64'(e.due));
        check("opc8", 64'(r8_rd_opc), 64'(e.opc));
        check("res8", 64'(r8_rd_res), e.res);
        check("valid8", 64'(r8_rd_valid), 64'd1);
        check("err8", 64'(r8_rd_err), 64'(e.err));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with load_en still high.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int unsigned ptr, input logic [31:0] res, input logic err,
                      input int unsigned lat, output int unsigned acc);
    exp_t e;
    opcode = op; operand_a = a; operand_b = b; write_pointer = ptr[4:0]; load_en = 1'b1;
    for (int i = 0; i < 100 && load_ready !== 1'b1; i++) @(negedge clk);
    acc = 0;
    if (load_ready !== 1'b1) begin
      check("accept_timeout32", 64'd0, 64'd1);
      load_en = 1'b0;
      return;
    end
    acc = cyc + 1;
    e = '{ptr: ptr, opc: op, a: 64'(a), b: 64'(b), res: 64'(res), err: err, due: acc + lat};
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int unsigned ptr, input logic [7:0] res, input logic err,
                       input int unsigned lat);
    exp_t e;
    r8_opcode = op; r8_a = a; r8_b = b; r8_wp = ptr[1:0]; r8_load_en = 1'b1;
    for (int i = 0; i < 100 && r8_load_ready !== 1'b1; i++) @(negedge clk);
    if (r8_load_ready !== 1'b1) begin
      check("accept_timeout8", 64'd0, 64'd1);
      r8_load_en = 1'b0;
      return;
    end
    e = '{ptr: ptr, opc: op, a: 64'(a), b: 64'(b), res: 64'(res), err: err, due: cyc + 1 + lat};
    sbq8.push_back(e);
    @(negedge clk);
    r8_load_en = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (sbq.size() != 0 || sbq8.size() != 0); i++) @(negedge clk);
    if (sbq.size() != 0 || sbq8.size() != 0) check("drain_timeout", 64'(sbq.size() + sbq8.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1, a2, a3;
    reset_n = 1'b0; load_en = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    write_pointer = '0; read_pointer = '0;
    r8_reset_n = 1'b0; r8_load_en = 1'b0; r8_opcode = '0; r8_a = '0; r8_b = '0;
    r8_wp = '0; r8_rp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; r8_reset_n = 1'b1;
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    for (int i = 0; i < 32; i++) begin
      read_pointer = 5'(i);
      #1;
      check("rst_entry", {28'd0, rd_opc, rd_op_a}, 64'd0);
      check("rst_entry_b_res", {rd_op_b, rd_rezultat}, 64'd0);
      check("rst_entry_flags", 64'({rd_valid, rd_err}), 64'd0);
    end
    @(negedge clk);

    // back-to-back single-cycle ops with load_en held
    send(4'd3, 32'd7, 32'hFFFF_FFFD, 0, 32'd4, 1'b0, 1, a1);
    send(4'd4, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1'b0, 1, a2);
    send(4'd5, 32'h0001_0000, 32'h0001_0000, 2, 32'd0, 1'b0, 1, a3);
    load_en = 1'b0;
    check("b2b_accept_1", 64'(a2), 64'(a1 + 2));
    check("b2b_accept_2", 64'(a3), 64'(a2 + 2));

    send(4'd6, 32'hFFFF_FFF9, 32'd2, 5, 32'hFFFF_FFFD, 1'b0, 32, a1); load_en = 1'b0;
    send(4'd7, 32'hFFFF_FFF9, 32'd2, 6, 32'hFFFF_FFFF, 1'b0, 32, a1); load_en = 1'b0;
    send(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 7, 32'h8000_0000, 1'b0, 32, a1); load_en = 1'b0;
    send(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 12, 32'd0, 1'b0, 32, a1); load_en = 1'b0;
    send(4'd7, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 1'b0, 32, a1); load_en = 1'b0;
    send(4'd6, 32'd100, 32'hFFFF_FFF9, 11, 32'hFFFF_FFF2, 1'b0, 32, a1); load_en = 1'b0;
    send(4'd6, 32'd5, 32'd0, 8, 32'd0, 1'b1, 1, a1); load_en = 1'b0;
    send(4'd9, 32'd11, 32'd12, 9, 32'd0, 1'b1, 1, a1); load_en = 1'b0;
    send(4'd1, 32'hDEAD_BEEF, 32'd3, 13, 32'hDEAD_BEEF, 1'b0, 1, a1);
    send(4'd2, 32'd3, 32'h0000_1234, 0, 32'h0000_1234, 1'b0, 1, a1);
    send(4'd0, 32'd55, 32'd66, 31, 32'd0, 1'b0, 1, a1);
    load_en = 1'b0;
    drain();

    // reset in the middle of a divide: nothing commits, no done
    opcode = 4'd6; operand_a = 32'd100; operand_b = 32'd3; write_pointer = 5'd2; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check("div_busy", 64'(load_ready), 64'd0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_ready", 64'(load_ready), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    read_pointer = 5'd2;
    #1;
    check("midrst_valid", 64'(rd_valid), 64'd0);
    read_pointer = 5'd0;
    #1;
    check("midrst_entry0_cleared", {31'd0, rd_valid, rd_rezultat}, 64'd0);
    repeat (40) @(negedge clk);

    // narrow instance: pointer wrap, signed overflow, 8-cycle divide
    send8(4'd3, 8'd127, 8'd1, 3, 8'h80, 1'b0, 1);
    send8(4'd3, 8'd5, 8'd6, 0, 8'd11, 1'b0, 1);
    send8(4'd6, 8'h9C, 8'd7, 1, 8'hF2, 1'b0, 8);
    send8(4'd7, 8'h9C, 8'd7, 2, 8'hFE, 1'b0, 8);
    send8(4'd6, 8'h80, 8'hFF, 2, 8'h80, 1'b0, 8);
    send8(4'd7, 8'd9, 8'd0, 1, 8'd0, 1'b1, 1);
    drain();
    r8_rp = 2'd3;
    #1;
    check("w8_ptr3_kept", 64'(r8_rd_res), 64'h80);
    r8_rp = 2'd0;
    #1;
    check("w8_ptr0", 64'(r8_rd_res), 64'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
